// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine sequencer: state encoding and actuator bit positions.
package wm_pkg;

    localparam logic [3:0] EncIdle  = 4'd0;
    localparam logic [3:0] EncFill  = 4'd1;
    localparam logic [3:0] EncDet   = 4'd2;
    localparam logic [3:0] EncWash  = 4'd3;
    localparam logic [3:0] EncDrain = 4'd4;
    localparam logic [3:0] EncSpin  = 4'd5;
    localparam logic [3:0] EncDone  = 4'd6;
    localparam logic [3:0] EncFault = 4'd7;

    typedef enum logic [3:0] {
        StIdle  = EncIdle,
        StFill  = EncFill,
        StDet   = EncDet,
        StWash  = EncWash,
        StDrain = EncDrain,
        StSpin  = EncSpin,
        StDone  = EncDone,
        StFault = EncFault
    } wm_state_e;

    localparam int unsigned ACT_MOTOR = 0;
    localparam int unsigned ACT_FILL  = 1;
    localparam int unsigned ACT_DRAIN = 2;
    localparam int unsigned ACT_LOCK  = 3;
    localparam int unsigned ACT_W     = 4;

    function automatic logic locks_door(wm_state_e s);
        return !(s inside {StIdle, StDone, StFault});
    endfunction

endpackage

// File: rtl/wm_multi_rinse_ctrl_if.sv
// Sensor/actuator bundle of the washing-machine sequencer; slave is the controller side.
interface wm_multi_rinse_ctrl_if;

    logic       start;
    logic       door_close;
    logic       filled;
    logic       detergent_added;
    logic       drained;
    logic       pause;
    logic       door_lock;
    logic       motor_on;
    logic       fill_valve_on;
    logic       drain_valve_on;
    logic       soap_wash;
    logic       water_wash;
    logic       done;
    logic [2:0] rinse_idx;
    logic [3:0] state_o;
    logic       fault;

    modport master (
        output start, door_close, filled, detergent_added, drained, pause,
        input  door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash, water_wash,
        input  done, rinse_idx, state_o, fault
    );

    modport slave (
        input  start, door_close, filled, detergent_added, drained, pause,
        output door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash, water_wash,
        output done, rinse_idx, state_o, fault
    );

endinterface

// File: rtl/wm_cycle_timer.sv
// Loadable down-counter with hold; zero_o flags an expired count. Shared by WASH and SPIN.
module wm_cycle_timer #(
    parameter int unsigned TMR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             hold_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wm_multi_rinse_ctrl.sv
// Washing-machine sequencer: soap wash, RINSE_CNT rinses, spin, with pause and registered outputs.
// Define WM_WATCHDOG_EN to add the FILL/DRAIN watchdog and the latched FAULT state.
module wm_multi_rinse_ctrl
    import wm_pkg::*;
#(
    parameter int unsigned RINSE_CNT   = 2,
    parameter int unsigned WASH_CYCLES = 16,
    parameter int unsigned SPIN_CYCLES = 8,
    parameter int unsigned TMR_W       = 8,
    parameter int unsigned FILL_TMO    = 64
) (
    input logic                  clk,
    input logic                  reset,
    wm_multi_rinse_ctrl_if.slave bus
);

    wm_state_e        state_q, state_d;
    logic [2:0]       rinse_q, rinse_d;
    logic             hold, timing, tmr_zero, tmr_load, wd_trip;
    logic [TMR_W-1:0] tmr_val;
    logic [ACT_W-1:0] act_q, act_d;
    logic             done_q, done_d, soap_q, soap_d, water_q, water_d, fault_q, fault_d;

    if (RINSE_CNT > 7 || WASH_CYCLES < 1 || SPIN_CYCLES < 1 || FILL_TMO < 1 ||
        WASH_CYCLES >= (1 << TMR_W) || SPIN_CYCLES >= (1 << TMR_W)) begin : g_bad_params
        $error("wm_multi_rinse_ctrl: illegal parameter set");
    end

    // Pause freezes every state except the IDLE/DONE handshakes.
    assign hold   = bus.pause && (state_q != StIdle) && (state_q != StDone);
    assign timing = (state_q == StWash) || (state_q == StSpin);

`ifdef WM_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(FILL_TMO + 1);
    logic [WdW-1:0] wd_q, wd_d;

    assign wd_trip = !hold && (state_q == StFill || state_q == StDrain) &&
                     (wd_q == WdW'(FILL_TMO - 1));

    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (!hold && (state_q == StFill || state_q == StDrain)) begin
            wd_d = wd_q + WdW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_trip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rinse_d = rinse_q;
        if (!hold) begin
            unique case (state_q)
                StIdle:  if (bus.start && bus.door_close) state_d = StFill;
                StFill: begin
                    if (bus.filled) state_d = (rinse_q == 3'd0) ? StDet : StWash;
                    else if (wd_trip) state_d = StFault;
                end
                StDet:   if (bus.detergent_added) state_d = StWash;
                StWash:  if (tmr_zero) state_d = StDrain;
                StDrain: begin
                    if (bus.drained) begin
                        if (rinse_q < 3'(RINSE_CNT)) begin
                            rinse_d = rinse_q + 3'd1;
                            state_d = StFill;
                        end else begin
                            state_d = StSpin;
                        end
                    end else if (wd_trip) begin
                        state_d = StFault;
                    end
                end
                StSpin:  if (tmr_zero) state_d = StDone;
                StDone: begin
                    state_d = StIdle;
                    rinse_d = '0;
                end
                StFault: state_d = StFault;
                default: state_d = StIdle;
            endcase
        end
    end

    // Timer is (re)armed on entry so WASH/SPIN last exactly their cycle count.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state_d != state_q) begin
            if (state_d == StWash) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(WASH_CYCLES - 1);
            end else if (state_d == StSpin) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(SPIN_CYCLES - 1);
            end
        end
    end

    wm_cycle_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (reset),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .hold_i    (hold || !timing),
        .zero_o    (tmr_zero)
    );

    always_comb begin
        act_d = '0;
        case (state_d)
            StFill:  act_d[ACT_FILL] = 1'b1;
            StWash:  act_d[ACT_MOTOR] = 1'b1;
            StDrain: act_d[ACT_DRAIN] = 1'b1;
            StSpin: begin
                act_d[ACT_MOTOR] = 1'b1;
                act_d[ACT_DRAIN] = 1'b1;
            end
            default: act_d = '0;
        endcase
        if (hold) begin
            act_d[ACT_MOTOR] = 1'b0;
            act_d[ACT_FILL]  = 1'b0;
            act_d[ACT_DRAIN] = 1'b0;
        end
        act_d[ACT_LOCK] = locks_door(state_d);
        done_d  = (state_d == StDone);
        soap_d  = (rinse_d == 3'd0) && (state_d inside {StFill, StDet, StWash, StDrain});
        water_d = (rinse_d != 3'd0) && (state_d != StIdle) && (state_d != StDone);
`ifdef WM_WATCHDOG_EN
        fault_d = (state_d == StFault);
`else
        fault_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rinse_q <= '0;
            act_q   <= '0;
            done_q  <= 1'b0;
            soap_q  <= 1'b0;
            water_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rinse_q <= rinse_d;
            act_q   <= act_d;
            done_q  <= done_d;
            soap_q  <= soap_d;
            water_q <= water_d;
            fault_q <= fault_d;
        end
    end

    assign bus.door_lock      = act_q[ACT_LOCK];
    assign bus.motor_on       = act_q[ACT_MOTOR];
    assign bus.fill_valve_on  = act_q[ACT_FILL];
    assign bus.drain_valve_on = act_q[ACT_DRAIN];
    assign bus.soap_wash      = soap_q;
    assign bus.water_wash     = water_q;
    assign bus.done           = done_q;
    assign bus.rinse_idx      = rinse_q;
    assign bus.state_o        = state_q;
    assign bus.fault          = fault_q;

endmodule

// File: tb/tb_wm_multi_rinse_ctrl.sv
// Bench for wm_multi_rinse_ctrl: RINSE_CNT=2 and RINSE_CNT=0 instances against a phase-level model.
module tb_wm_multi_rinse_ctrl;

    localparam int WashCycles = 16;
    localparam int SpinCycles = 8;
    localparam int FillTmo    = 64;
    localparam int MIdle = 0, MFill = 1, MDet = 2, MWash = 3, MDrain = 4, MSpin = 5, MDone = 6,
                   MFault = 7;
`ifdef WM_WATCHDOG_EN
    localparam bit WdOn = 1'b1;
`else
    localparam bit WdOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start, door_close, filled, detergent_added, drained, pause;
    always #5 clk = ~clk;

    wm_multi_rinse_ctrl_if bus_a ();
    wm_multi_rinse_ctrl_if bus_b ();

    assign bus_a.start = start;           assign bus_b.start = start;
    assign bus_a.door_close = door_close; assign bus_b.door_close = door_close;
    assign bus_a.filled = filled;         assign bus_b.filled = filled;
    assign bus_a.detergent_added = detergent_added;
    assign bus_b.detergent_added = detergent_added;
    assign bus_a.drained = drained;       assign bus_b.drained = drained;
    assign bus_a.pause = pause;           assign bus_b.pause = pause;

    wm_multi_rinse_ctrl #(.RINSE_CNT(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    wm_multi_rinse_ctrl #(.RINSE_CNT(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int n_vec, n_err;
    int m_st[2], m_ri[2], m_el[2], m_wait[2];
    bit m_hold[2];
    int rc[2] = '{2, 0};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_st[k] = MIdle; m_ri[k] = 0; m_el[k] = 0; m_wait[k] = 0; m_hold[k] = 1'b0;
    endtask

    // One clock of the washing programme, stated in phases and elapsed-cycle counts.
    task automatic model_step(input int k);
        int nxt;
        bit hold;
        nxt  = m_st[k];
        hold = pause && m_st[k] != MIdle && m_st[k] != MDone;
        if (!hold) begin
            case (m_st[k])
                MIdle: if (start && door_close) nxt = MFill;
                MFill: begin
                    m_wait[k]++;
                    if (filled) nxt = (m_ri[k] == 0) ? MDet : MWash;
                    else if (WdOn && m_wait[k] == FillTmo) nxt = MFault;
                end
                MDet: if (detergent_added) nxt = MWash;
                MWash: begin
                    m_el[k]++;
                    if (m_el[k] == WashCycles) nxt = MDrain;
                end
                MDrain: begin
                    m_wait[k]++;
                    if (drained) begin
                        if (m_ri[k] < rc[k]) begin
                            m_ri[k]++;
                            nxt = MFill;
                        end else begin
                            nxt = MSpin;
                        end
                    end else if (WdOn && m_wait[k] == FillTmo) begin
                        nxt = MFault;
                    end
                end
                MSpin: begin
                    m_el[k]++;
                    if (m_el[k] == SpinCycles) nxt = MDone;
                end
                MDone: begin
                    m_ri[k] = 0;
                    nxt = MIdle;
                end
                default: ;
            endcase
        end
        if (nxt != m_st[k]) begin
            m_el[k] = 0;
            m_wait[k] = 0;
        end
        m_st[k] = nxt;
        m_hold[k] = hold;
    endtask

    function automatic logic [15:0] model_out(input int k);
        int s;
        bit h;
        logic [15:0] v;
        s = m_st[k];
        h = m_hold[k];
        v[15:12] = 4'(s);
        v[11:9]  = 3'(m_ri[k]);
        v[8] = !(s == MIdle || s == MDone || s == MFault);
        v[7] = !h && (s == MWash || s == MSpin);
        v[6] = !h && (s == MFill);
        v[5] = !h && (s == MDrain || s == MSpin);
        v[4] = (m_ri[k] == 0) && (s >= MFill) && (s <= MDrain);
        v[3] = (m_ri[k] != 0) && (s != MIdle) && (s != MDone);
        v[2] = (s == MDone);
        v[1] = (s == MFault);
        v[0] = 1'b0;
        return v;
    endfunction

    function automatic logic [15:0] pack(input logic [3:0] st, input logic [2:0] ri,
                                         input logic l, input logic m, input logic f,
                                         input logic d, input logic sw, input logic ww,
                                         input logic dn, input logic ft);
        return {st, ri, l, m, f, d, sw, ww, dn, ft, 1'b0};
    endfunction

    task automatic check_both(input string tag);
        check_eq({tag, "_a"}, pack(bus_a.state_o, bus_a.rinse_idx, bus_a.door_lock,
                 bus_a.motor_on, bus_a.fill_valve_on, bus_a.drain_valve_on, bus_a.soap_wash,
                 bus_a.water_wash, bus_a.done, bus_a.fault), model_out(0));
        check_eq({tag, "_b"}, pack(bus_b.state_o, bus_b.rinse_idx, bus_b.door_lock,
                 bus_b.motor_on, bus_b.fill_valve_on, bus_b.drain_valve_on, bus_b.soap_wash,
                 bus_b.water_wash, bus_b.done, bus_b.fault), model_out(1));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!reset) model_reset(k);
            else model_step(k);
        end
        @(negedge clk);
        check_both("outs");
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) model_reset(k);
        check_both("rst_async");
        tick();
        reset = 1'b1;
    endtask

    // Sensors answer the instance-A request one cycle after it appears.
    task automatic respond();
        filled = (m_st[0] == MFill);
        detergent_added = (m_st[0] == MDet);
        drained = (m_st[0] == MDrain);
    endtask

    initial begin
        int wash_cnt[3];
        int det_visits, spin_cnt, done_cnt, prev_a, prev_b, pause_left, wlen, fill_cnt;
        bit fin, water_b_seen, done_seen, paused_now;
        int b_seq[$];
        int b_exp[7] = '{MFill, MDet, MWash, MDrain, MSpin, MDone, MIdle};

        n_vec = 0; n_err = 0;
        reset = 1'b0; start = 0; door_close = 0; filled = 0; detergent_added = 0;
        drained = 0; pause = 0;
        for (int k = 0; k < 2; k++) model_reset(k);
        @(negedge clk);
        check_both("reset");
        reset = 1'b1;

        // start without a closed door is refused
        start = 1; door_close = 0;
        repeat (3) tick();
        check_eq("idle_no_door", 16'(bus_a.state_o), 16'(MIdle));
        check_eq("idle_unlock", 16'(bus_a.door_lock), 16'd0);
        door_close = 1;
        tick();
        check_eq("start_fill", 16'(bus_a.state_o), 16'(MFill));
        check_eq("start_valve", 16'(bus_a.fill_valve_on), 16'd1);
        start = 0;

        // full programme with prompt sensors
        wash_cnt = '{0, 0, 0};
        det_visits = 0; spin_cnt = 0; done_cnt = 0; fin = 0; water_b_seen = 0;
        prev_a = MFill; prev_b = MFill;
        b_seq.push_back(MFill);
        for (int c = 0; c < 400 && !fin; c++) begin
            respond();
            tick();
            if (bus_a.state_o == 4'(MWash) && bus_a.rinse_idx < 3) wash_cnt[bus_a.rinse_idx]++;
            if (bus_a.state_o == 4'(MDet) && prev_a != MDet) det_visits++;
            if (bus_a.state_o == 4'(MSpin)) spin_cnt++;
            if (bus_a.done) done_cnt++;
            if (bus_a.state_o == 4'(MIdle)) fin = 1;
            prev_a = int'(bus_a.state_o);
            if (int'(bus_b.state_o) != prev_b) b_seq.push_back(int'(bus_b.state_o));
            prev_b = int'(bus_b.state_o);
            if (bus_b.water_wash) water_b_seen = 1;
        end
        check_eq("run_end", 16'(fin), 16'd1);
        for (int i = 0; i < 3; i++) check_eq("wash_len", 16'(wash_cnt[i]), 16'(WashCycles));
        check_eq("det_visits", 16'(det_visits), 16'd1);
        check_eq("spin_len", 16'(spin_cnt), 16'(SpinCycles));
        check_eq("done_len", 16'(done_cnt), 16'd1);
        check_eq("unlock_after", 16'(bus_a.door_lock), 16'd0);
        check_eq("b_seq_len", 16'(b_seq.size()), 16'd7);
        for (int i = 0; i < 7; i++)
            check_eq("b_seq", 16'((i < b_seq.size()) ? b_seq[i] : 99), 16'(b_exp[i]));
        check_eq("b_no_water", 16'(water_b_seen), 16'd0);

        // pause of 5 cycles during the soap WASH, with a stray filled
        start = 1; door_close = 1;
        tick();
        start = 0;
        wlen = 0; pause_left = -1; fin = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            respond();
            paused_now = 0;
            if (pause_left > 0) begin
                pause = 1; filled = 1; pause_left--; paused_now = 1;
            end else begin
                pause = 0;
            end
            tick();
            if (paused_now) check_eq("pause_motor", 16'(bus_a.motor_on), 16'd0);
            if (bus_a.state_o == 4'(MWash) && bus_a.rinse_idx == 3'd0) begin
                wlen++;
                if (wlen == 10 && pause_left < 0) pause_left = 5;
            end else if (wlen > 0) begin
                fin = 1;
            end
        end
        pause = 0;
        check_eq("pause_wash_len", 16'(wlen), 16'(WashCycles + 5));

        // reset in the middle of the first rinse WASH
        fin = 0;
        for (int c = 0; c < 100 && !fin; c++) begin
            respond();
            tick();
            if (bus_a.state_o == 4'(MWash) && bus_a.rinse_idx == 3'd1) fin = 1;
        end
        check_eq("reach_rinse_wash", 16'(fin), 16'd1);
        repeat (4) tick();
        pulse_reset();
        filled = 0; detergent_added = 0; drained = 0;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus_a.done || bus_b.done) done_seen = 1;
        end
        check_eq("no_done_after_rst", 16'(done_seen), 16'd0);

`ifdef WM_WATCHDOG_EN
        start = 1; door_close = 1;
        tick();
        start = 0;
        fill_cnt = 0;
        for (int c = 0; c < 200 && bus_a.state_o == 4'(MFill); c++) begin
            fill_cnt++;
            tick();
        end
        check_eq("wd_fill_len", 16'(fill_cnt), 16'(FillTmo));
        check_eq("wd_fault", {bus_a.state_o, bus_a.fault, bus_a.fill_valve_on, bus_a.door_lock},
                 {4'(MFault), 1'b1, 1'b0, 1'b0});
        pulse_reset();
`else
        fill_cnt = 0;
`endif

        // randomized traffic, occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 3) == 0);
            door_close = ($urandom_range(0, 9) < 7);
            filled = ($urandom_range(0, 3) == 0);
            detergent_added = ($urandom_range(0, 3) == 0);
            drained = ($urandom_range(0, 3) == 0);
            pause = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 399) == 0) pulse_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
